uart_cmd_rx: RTL and testbench

Parametrised UART command receiver. It replaces the fixed 8N1 / 9600-baud receive path in front of the SD command logic. It oversamples the host serial line, assembles bytes with optional parity, and parses host command frames of the form [length, MSB first][opcode][payload × length]. Decoded opcode, length and payload bytes go to the SD/FIFO control logic as single-cycle strobes, and error pulses are raised for framing, parity and inter-byte timeout.

---
 rtl/uart_cmd_rx_if.sv | 26 ++
 rtl/uart_cmd_rx.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_rx_if.sv
// Decoded-command bundle from uart_cmd_rx to the SD/FIFO control logic.
// The receiver drives every signal; consumers only observe.
interface uart_cmd_rx_if #(
    parameter int DATA_BITS = 8,
    parameter int LEN_BYTES = 2
);
    logic                     cmd_valid;
    logic [DATA_BITS-1:0]     cmd_op;
    logic [8*LEN_BYTES-1:0]   cmd_len;
    logic                     pay_valid;
    logic [DATA_BITS-1:0]     pay_data;
    logic                     pay_last;
    logic                     frame_done;
    logic                     err_frame;
    logic                     err_parity;
    logic                     err_timeout;

    modport master (
        output cmd_valid, cmd_op, cmd_len, pay_valid, pay_data, pay_last,
               frame_done, err_frame, err_parity, err_timeout
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_len, pay_valid, pay_data, pay_last,
               frame_done, err_frame, err_parity, err_timeout
    );
endinterface

// File: rtl/uart_cmd_rx.sv
// Oversampling UART receiver plus [length][opcode][payload] frame parser
// with framing/parity/inter-byte timeout error pulses.
//   rx state | meaning              parser | meaning
//   IDLE     | wait for start edge  HDR    | collecting length bytes
//   START    | mid-start check      OP     | next byte is the opcode
//   DATA     | shifting data bits   PAY    | counting payload bytes
//   PAR      | parity sample
//   STOP     | stop sample, verdict
//   BREAK    | line held low, wait for high
module uart_cmd_rx #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int LEN_BYTES    = 2,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mosi,
    uart_cmd_rx_if.master rx_if
);
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int CNT_W  = $clog2(DIV);
    localparam int LW     = 8 * LEN_BYTES;
    localparam int TO_MAX = TIMEOUT_BITS * DIV;
    localparam int TO_W   = $clog2(TO_MAX + 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK} rx_state_t;
    typedef enum logic [1:0] {P_HDR, P_OP, P_PAY} p_state_t;

    logic                 sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
    rx_state_t            rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 byte_stb_q, byte_stb_d;
    logic                 err_frame_q, err_frame_d, err_parity_q, err_parity_d;

    p_state_t             p_state_q, p_state_d;
    logic [1:0]           hdr_idx_q, hdr_idx_d;
    logic [LW-1:0]        len_q, len_d, rem_q, rem_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic                 err_timeout_q, err_timeout_d;
    logic                 cmd_valid_q, cmd_valid_d, pay_valid_q, pay_valid_d;
    logic                 pay_last_q, pay_last_d, frame_done_q, frame_done_d;
    logic [DATA_BITS-1:0] cmd_op_q, cmd_op_d, pay_data_q, pay_data_d;
    logic [LW-1:0]        cmd_len_q, cmd_len_d;

    logic fall, bit_tick, par_exp, to_active, to_hit;

    always_comb begin
        sync1_d  = mosi;
        sync2_d  = sync1_q;
        hist_d   = sync2_q;
        fall     = hist_q & ~sync2_q;
        bit_tick = (bit_cnt_q == '0);
        par_exp  = (PARITY == 1) ? ~(^shift_q) : (^shift_q);
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        bit_cnt_d    = bit_tick ? bit_cnt_q : bit_cnt_q - 1'b1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_err_d    = par_err_q;
        byte_stb_d   = 1'b0;
        err_frame_d  = 1'b0;
        err_parity_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (fall) begin
                rx_state_d = RX_START;
                bit_cnt_d  = CNT_W'(DIV / 2 - 1);
                bit_idx_d  = '0;
                par_err_d  = 1'b0;
            end
            RX_START: if (bit_tick) begin
                if (!sync2_q) begin
                    rx_state_d = RX_DATA;
                    bit_cnt_d  = CNT_W'(DIV - 1);
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_DATA: if (bit_tick) begin
                shift_d   = {sync2_q, shift_q[DATA_BITS-1:1]};
                bit_cnt_d = CNT_W'(DIV - 1);
                bit_idx_d = bit_idx_q + 1'b1;
                if (bit_idx_q == 3'(DATA_BITS - 1))
                    rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
            end
            RX_PAR: if (bit_tick) begin
                par_err_d  = (sync2_q != par_exp);
                bit_cnt_d  = CNT_W'(DIV - 1);
                rx_state_d = RX_STOP;
            end
            RX_STOP: if (bit_tick) begin
                if (sync2_q) begin
                    err_parity_d = par_err_q;
                    byte_stb_d   = ~par_err_q;
                    rx_state_d   = RX_IDLE;
                end else begin
                    err_frame_d  = 1'b1;
                    rx_state_d   = RX_BREAK;
                end
            end
            RX_BREAK: if (sync2_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // A start edge always clears the timer, so it beats a coincident expiry.
    always_comb begin
        to_active     = ((p_state_q != P_HDR) || (hdr_idx_q != '0)) && (rx_state_q == RX_IDLE);
        to_hit        = 1'b0;
        to_d          = '0;
        err_timeout_d = 1'b0;
        if (to_active && !fall) begin
            if (to_q == TO_W'(TO_MAX - 1)) to_hit = 1'b1;
            else                           to_d   = to_q + 1'b1;
        end
        err_timeout_d = to_hit;
    end

    always_comb begin
        p_state_d    = p_state_q;
        hdr_idx_d    = hdr_idx_q;
        len_d        = len_q;
        rem_d        = rem_q;
        cmd_op_d     = cmd_op_q;
        cmd_len_d    = cmd_len_q;
        pay_data_d   = pay_data_q;
        cmd_valid_d  = 1'b0;
        pay_valid_d  = 1'b0;
        pay_last_d   = 1'b0;
        frame_done_d = 1'b0;
        if (err_frame_q || err_parity_q || to_hit) begin
            p_state_d = P_HDR;
            hdr_idx_d = '0;
        end else if (byte_stb_q) begin
            case (p_state_q)
                P_HDR: begin
                    len_d = (len_q << 8) | LW'(shift_q);
                    if (hdr_idx_q == 2'(LEN_BYTES - 1)) begin
                        hdr_idx_d = '0;
                        p_state_d = P_OP;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 1'b1;
                    end
                end
                P_OP: begin
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = shift_q;
                    cmd_len_d   = len_q;
                    rem_d       = len_q;
                    if (len_q == '0) begin
                        frame_done_d = 1'b1;
                        p_state_d    = P_HDR;
                    end else begin
                        p_state_d    = P_PAY;
                    end
                end
                P_PAY: begin
                    pay_valid_d = 1'b1;
                    pay_data_d  = shift_q;
                    rem_d       = rem_q - 1'b1;
                    if (rem_q == LW'(1)) begin
                        pay_last_d   = 1'b1;
                        frame_done_d = 1'b1;
                        p_state_d    = P_HDR;
                    end
                end
                default: p_state_d = P_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            hist_q        <= 1'b1;
            rx_state_q    <= RX_IDLE;
            bit_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            par_err_q     <= 1'b0;
            byte_stb_q    <= 1'b0;
            err_frame_q   <= 1'b0;
            err_parity_q  <= 1'b0;
            p_state_q     <= P_HDR;
            hdr_idx_q     <= '0;
            len_q         <= '0;
            rem_q         <= '0;
            to_q          <= '0;
            err_timeout_q <= 1'b0;
            cmd_valid_q   <= 1'b0;
            pay_valid_q   <= 1'b0;
            pay_last_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            cmd_op_q      <= '0;
            cmd_len_q     <= '0;
            pay_data_q    <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            hist_q        <= hist_d;
            rx_state_q    <= rx_state_d;
            bit_cnt_q     <= bit_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            par_err_q     <= par_err_d;
            byte_stb_q    <= byte_stb_d;
            err_frame_q   <= err_frame_d;
            err_parity_q  <= err_parity_d;
            p_state_q     <= p_state_d;
            hdr_idx_q     <= hdr_idx_d;
            len_q         <= len_d;
            rem_q         <= rem_d;
            to_q          <= to_d;
            err_timeout_q <= err_timeout_d;
            cmd_valid_q   <= cmd_valid_d;
            pay_valid_q   <= pay_valid_d;
            pay_last_q    <= pay_last_d;
            frame_done_q  <= frame_done_d;
            cmd_op_q      <= cmd_op_d;
            cmd_len_q     <= cmd_len_d;
            pay_data_q    <= pay_data_d;
        end
    end

    assign rx_if.cmd_valid   = cmd_valid_q;
    assign rx_if.cmd_op      = cmd_op_q;
    assign rx_if.cmd_len     = cmd_len_q;
    assign rx_if.pay_valid   = pay_valid_q;
    assign rx_if.pay_data    = pay_data_q;
    assign rx_if.pay_last    = pay_last_q;
    assign rx_if.frame_done  = frame_done_q;
    assign rx_if.err_frame   = err_frame_q;
    assign rx_if.err_parity  = err_parity_q;
    assign rx_if.err_timeout = err_timeout_q;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: serial frames in, strobes scoreboarded
// against expectations queued when each frame is sent.
module tb_uart_cmd_rx;
    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int DIV    = CLK_HZ / BAUD;

    typedef struct packed {
        logic       cv, pv, pl, fd, ef, ep, et;
        logic [7:0] op;
        logic [15:0] len;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mosi0 = 1'b1;
    logic mosi1 = 1'b1;
    int unsigned cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int t_to = -1;
    int t0 = 0;
    ev_t q0[$];
    ev_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_cmd_rx_if #(.DATA_BITS(8), .LEN_BYTES(2)) if0 ();
    uart_cmd_rx_if #(.DATA_BITS(8), .LEN_BYTES(2)) if1 ();

    uart_cmd_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                  .LEN_BYTES(2), .TIMEOUT_BITS(40))
        dut0 (.clk(clk), .rst_n(rst_n), .mosi(mosi0), .rx_if(if0));
    uart_cmd_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                  .LEN_BYTES(2), .TIMEOUT_BITS(40))
        dut1 (.clk(clk), .rst_n(rst_n), .mosi(mosi1), .rx_if(if1));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ev_t obs_of(input logic cv, pv, pl, fd, ef, ep, et,
                                   input logic [7:0] op, input logic [15:0] len,
                                   input logic [7:0] d);
        ev_t e;
        e.cv = cv; e.pv = pv; e.pl = pl; e.fd = fd;
        e.ef = ef; e.ep = ep; e.et = et;
        e.op   = cv ? op : 8'h00;
        e.len  = cv ? len : 16'h0000;
        e.data = pv ? d : 8'h00;
        return e;
    endfunction

    function automatic ev_t ev_cmd(input logic [7:0] op, input logic [15:0] len);
        ev_t e = '0;
        e.cv = 1'b1; e.op = op; e.len = len; e.fd = (len == 16'h0000);
        return e;
    endfunction

    function automatic ev_t ev_pay(input logic [7:0] d, input logic last);
        ev_t e = '0;
        e.pv = 1'b1; e.data = d; e.pl = last; e.fd = last;
        return e;
    endfunction

    function automatic ev_t ev_err(input int kind);
        ev_t e = '0;
        e.ef = (kind == 0); e.ep = (kind == 1); e.et = (kind == 2);
        return e;
    endfunction

    always @(negedge clk) begin
        ev_t o, x;
        if (rst_n && (if0.cmd_valid || if0.pay_valid || if0.frame_done ||
                      if0.err_frame || if0.err_parity || if0.err_timeout)) begin
            o = obs_of(if0.cmd_valid, if0.pay_valid, if0.pay_last, if0.frame_done,
                       if0.err_frame, if0.err_parity, if0.err_timeout,
                       if0.cmd_op, if0.cmd_len, if0.pay_data);
            x = '0;
            if (q0.size() > 0) x = q0.pop_front();
            check("dut0_event", 64'(o), 64'(x));
            if (if0.err_timeout) t_to = int'(cyc);
        end
    end

    always @(negedge clk) begin
        ev_t o, x;
        if (rst_n && (if1.cmd_valid || if1.pay_valid || if1.frame_done ||
                      if1.err_frame || if1.err_parity || if1.err_timeout)) begin
            o = obs_of(if1.cmd_valid, if1.pay_valid, if1.pay_last, if1.frame_done,
                       if1.err_frame, if1.err_parity, if1.err_timeout,
                       if1.cmd_op, if1.cmd_len, if1.pay_data);
            x = '0;
            if (q1.size() > 0) x = q1.pop_front();
            check("dut1_event", 64'(o), 64'(x));
        end
    end

    task automatic set_line(input int inst, input logic v);
        if (inst == 0) mosi0 = v;
        else           mosi1 = v;
    endtask

    task automatic wait_bits(input int n);
        repeat (n * DIV) @(posedge clk);
        #2;
    endtask

    task automatic send_char(input int inst, input logic [7:0] d, input bit par_en,
                             input bit par_bit, input bit stop_bit);
        set_line(inst, 1'b0);
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            set_line(inst, d[i]);
            wait_bits(1);
        end
        if (par_en) begin
            set_line(inst, par_bit);
            wait_bits(1);
        end
        set_line(inst, stop_bit);
        wait_bits(1);
        set_line(inst, 1'b1);
        wait_bits(2);
    endtask

    task automatic send0(input logic [7:0] d);
        send_char(0, d, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send1(input logic [7:0] d);
        send_char(1, d, 1'b1, ^d, 1'b1);
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_cmd_valid"},   64'(if0.cmd_valid),   64'd0);
        check({pfx, "_pay_valid"},   64'(if0.pay_valid),   64'd0);
        check({pfx, "_pay_last"},    64'(if0.pay_last),    64'd0);
        check({pfx, "_frame_done"},  64'(if0.frame_done),  64'd0);
        check({pfx, "_err_frame"},   64'(if0.err_frame),   64'd0);
        check({pfx, "_err_parity"},  64'(if0.err_parity),  64'd0);
        check({pfx, "_err_timeout"}, 64'(if0.err_timeout), 64'd0);
        check({pfx, "_cmd_op"},      64'(if0.cmd_op),      64'd0);
        check({pfx, "_cmd_len"},     64'(if0.cmd_len),     64'd0);
        check({pfx, "_pay_data"},    64'(if0.pay_data),    64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (5) @(posedge clk);
        #2;
        check_idle("reset");
        rst_n = 1'b1;
        wait_bits(1);

        // len 1 frame
        q0.push_back(ev_cmd(8'h02, 16'h0001));
        q0.push_back(ev_pay(8'h00, 1'b1));
        send0(8'h00); send0(8'h01); send0(8'h02); send0(8'h00);

        // len 4 frame
        q0.push_back(ev_cmd(8'h05, 16'h0004));
        q0.push_back(ev_pay(8'h12, 1'b0));
        q0.push_back(ev_pay(8'h34, 1'b0));
        q0.push_back(ev_pay(8'h56, 1'b0));
        q0.push_back(ev_pay(8'h78, 1'b1));
        send0(8'h00); send0(8'h04); send0(8'h05);
        send0(8'h12); send0(8'h34); send0(8'h56); send0(8'h78);

        // zero-length frame
        q0.push_back(ev_cmd(8'h07, 16'h0000));
        send0(8'h00); send0(8'h00); send0(8'h07);

        // framing error in header, then recovery
        q0.push_back(ev_err(0));
        send0(8'h00);
        send_char(0, 8'h01, 1'b0, 1'b0, 1'b0);
        q0.push_back(ev_cmd(8'h03, 16'h0001));
        q0.push_back(ev_pay(8'hAA, 1'b1));
        send0(8'h00); send0(8'h01); send0(8'h03); send0(8'hAA);

        // even parity: wrong parity bit aborts, good frame follows
        q1.push_back(ev_err(1));
        send1(8'h00);
        send_char(1, 8'h01, 1'b1, 1'b0, 1'b1);
        q1.push_back(ev_cmd(8'h09, 16'h0001));
        q1.push_back(ev_pay(8'h5A, 1'b1));
        send1(8'h00); send1(8'h01); send1(8'h09); send1(8'h5A);

        // short low glitch must not produce anything
        mosi1 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        mosi1 = 1'b1;
        wait_bits(3);
        check("glitch_q1_drained", 64'(q1.size()), 64'd0);

        // inter-byte timeout
        t_to = -1;
        t0 = int'(cyc);
        q0.push_back(ev_err(2));
        send0(8'h00);
        wait_bits(50);
        check("timeout_seen", 64'(t_to >= 0), 64'd1);
        check("timeout_delay_in_window",
              64'(((t_to - t0) >= 49 * DIV) && ((t_to - t0) <= 51 * DIV)), 64'd1);

        // reset mid-payload drops the frame
        q0.push_back(ev_cmd(8'h05, 16'h0004));
        q0.push_back(ev_pay(8'h12, 1'b0));
        send0(8'h00); send0(8'h04); send0(8'h05); send0(8'h12);
        set_line(0, 1'b0);
        wait_bits(1);
        for (int i = 0; i < 4; i++) begin
            set_line(0, (i % 2) == 0);
            wait_bits(1);
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_idle("midreset");
        mosi0 = 1'b1;
        wait_bits(1);
        rst_n = 1'b1;
        wait_bits(2);
        q0.push_back(ev_cmd(8'h0B, 16'h0002));
        q0.push_back(ev_pay(8'hC3, 1'b0));
        q0.push_back(ev_pay(8'hD4, 1'b1));
        send0(8'h00); send0(8'h02); send0(8'h0B); send0(8'hC3); send0(8'hD4);

        wait_bits(2);
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
